pwm_multi_dac: RTL and testbench
================================

// Module: pwm_multi_dac
// PURPOSE
//  Multi-channel PWM DAC: one shared period counter drives CHANNELS comparators.
//  Edge- or centre-aligned, programmable period, double-buffered duty words.
//  New duty sets apply only at a period boundary, so no partial or glitched
//  cycles. Sits between a register/stream source and the analog RC filters.
// PARAMETERS
//  WIDTH          10  counter, period and per-channel duty width (bits)
//  CHANNELS       4   number of PWM outputs
//  CENTER_ALIGNED 0   0 = sawtooth (up-count, wrap); 1 = triangle (up/down)
//  POLARITY       1   1 = active-high outputs; 0 = outputs inverted
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 reset: synchronous, active-high
//  en            in   1                 run enable
//  period        in   WIDTH             counter top value P; sampled at boundary
//  duty_in       in   CHANNELS*WIDTH    duty words, ch0 = bits [WIDTH-1:0]
//  duty_valid    in   1                 duty_in valid
//  duty_ready    out  1                 pending buffer empty, can accept
//  pwm_out       out  CHANNELS          registered PWM outputs
//  period_start  out  1                 1-cycle pulse: count==0 at period start
//  count         out  WIDTH             current counter value (debug/sync)
// BEHAVIOUR
//  Reset: count=0, dir=UP, P_act=0, duty_act=0, pending empty,
//   duty_ready=1, period_start=0, pwm_out = inactive level (~POLARITY).
//  Duty handshake: accept when duty_valid & duty_ready; word goes to pending.
//   duty_ready = !pending_full. No bypass: a word accepted on a boundary
//   cycle is applied at the following boundary.
//  Boundary (tick) = cycle whose clock edge returns count to 0 for a new period:
//   edge mode: count==P_act; centre mode: dir==DOWN & count==1;
//   P_act==0 (either mode): every cycle is a tick, count held at 0.
//  At a tick: P_act<=period; if pending_full, duty_act<=pending and pending
//   cleared (duty_ready rises the next cycle).
//  Counter (en=1): edge: 0,1..P,0,... (P+1 cycles).
//   Centre: 0,1..P,P-1..1,0,... (2P cycles); dir UP->DOWN when count==P,
//   DOWN->UP on the tick.
//  en=0: count forced 0, dir=UP, pwm_out inactive, period_start=0; every
//   cycle is a tick (period/pending still load). When en rises, the first
//   period starts at count=0 with the latest values.
//  pwm_out[i] registered: value at cycle t+1 = POLARITY ~^ (duty_act[i] > count)
//   evaluated at cycle t (1-cycle latency). Unsigned compare.
//   Edge high time = min(d, P+1) cycles; d=0 -> 0%, d>P -> 100%.
//   Centre high time = 0 if d=0, 2d-1 if 1<=d<=P, 2P if d>P.
//  period_start registered: high the cycle after a tick while en=1.
//  Period change applies only at a tick; the current period completes
//   unchanged. All arithmetic is WIDTH-bit, so P=2^WIDTH-1 is legal. Count
//   never exceeds P_act.
//  rst mid-period: immediate return to reset state; pending word discarded.
// TESTING
//  Edge, WIDTH=4, P=9, ch0 d=3 -> pwm_out[0] high 3 of every 10 cycles;
//   period_start every 10 cycles.
//  Edge, d=0 and d=15 with P=9 -> constant inactive / constant active.
//  Centre, P=8, d=4 -> period 16 cycles, high 7 cycles, centred on count 0.
//  Write d=2 mid-period then d=7 while duty_ready=0 -> second write stalls.
//   d=2 applies at the next tick; d=7 is accepted after that and applies
//   at the following tick.
//  Change P 9->4 mid-period -> current period stays 10 cycles, next is 5.
//   P=0 -> count stays 0.
//  Assert rst mid-period with a word pending -> next cycle: outputs inactive,
//   count=0, duty_ready=1. en=0 -> outputs inactive, count=0.

Source files
------------

// File: rtl/pwm_multi_dac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_multi_dac : shared-counter multi-channel PWM DAC, edge/centre aligned,
//                 double-buffered duty words applied only at period boundaries
// Revision      : 1.0
// ---------------------------------------------------------------------------
module pwm_multi_dac #(
  parameter int WIDTH          = 10,
  parameter int CHANNELS       = 4,
  parameter bit CENTER_ALIGNED = 1'b0,
  parameter bit POLARITY       = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      duty_valid,
  output logic                      duty_ready,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic [WIDTH-1:0]          count
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_t                      dir;
  dir_t                      dir_nxt;
  logic [WIDTH-1:0]          count_nxt;
  logic [WIDTH-1:0]          p_act;
  logic [CHANNELS*WIDTH-1:0] pending;
  logic                      pending_full;
  logic                      tick;
  logic                      accept;
  logic [WIDTH-1:0]          duty_act [CHANNELS];
  logic [CHANNELS-1:0]       pwm_nxt;

  assign duty_ready = !pending_full;
  assign accept     = duty_valid && !pending_full;

  // Counter/direction next state. In centre mode P=1 has no down leg, so the
  // boundary is taken directly at the top.
  always_comb begin
    tick      = 1'b0;
    count_nxt = count + ONE;
    dir_nxt   = dir;
    if (!en || (p_act == '0)) begin
      tick = 1'b1;
    end else if (CENTER_ALIGNED) begin
      tick = (count == ONE) && ((dir == DIR_DOWN) || (p_act == ONE));
    end else begin
      tick = (count == p_act);
    end

    if (tick) begin
      count_nxt = '0;
      dir_nxt   = DIR_UP;
    end else if (CENTER_ALIGNED) begin
      if (dir == DIR_DOWN) begin
        count_nxt = count - ONE;
      end else if (count == p_act) begin
        count_nxt = count - ONE;
        dir_nxt   = DIR_DOWN;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign pwm_nxt[g] = en ? (POLARITY ~^ (duty_act[g] > count)) : ~POLARITY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      dir          <= DIR_UP;
      p_act        <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      pwm_out      <= {CHANNELS{~POLARITY}};
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= '0;
      end
    end else begin
      count        <= count_nxt;
      dir          <= dir_nxt;
      pwm_out      <= pwm_nxt;
      period_start <= tick && en;
      if (tick) begin
        p_act <= period;
        if (pending_full) begin
          for (int i = 0; i < CHANNELS; i++) begin
            duty_act[i] <= pending[i*WIDTH +: WIDTH];
          end
          pending_full <= 1'b0;
        end
      end
      // Accept and boundary-consume are mutually exclusive (ready = !full).
      if (accept) begin
        pending      <= duty_in;
        pending_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_dac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_multi_dac : edge (active-high) and centre (active-low) instances
//                    checked every cycle against a period-phase model
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_pwm_multi_dac;

  localparam int W  = 4;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            duty_valid = 1'b0;
  logic [W-1:0]    period_e = '0;
  logic [W-1:0]    period_c = '0;
  logic [CH*W-1:0] duty_in = '0;
  logic            ready_e, ready_c, ps_e, ps_c;
  logic [CH-1:0]   pwm_e, pwm_c;
  logic [W-1:0]    cnt_e, cnt_c;

  always #5 clk = ~clk;

  pwm_multi_dac #(.WIDTH(W), .CHANNELS(CH), .CENTER_ALIGNED(1'b0), .POLARITY(1'b1)) u_edge (
    .clk(clk), .rst(rst), .en(en), .period(period_e), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(ready_e), .pwm_out(pwm_e),
    .period_start(ps_e), .count(cnt_e)
  );

  pwm_multi_dac #(.WIDTH(W), .CHANNELS(CH), .CENTER_ALIGNED(1'b1), .POLARITY(1'b0)) u_ctr (
    .clk(clk), .rst(rst), .en(en), .period(period_c), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(ready_c), .pwm_out(pwm_c),
    .period_start(ps_c), .count(cnt_c)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: index 0 = edge/active-high, 1 = centre/active-low. The period is
  // described by a phase k in [0, len) and the count derived from it.
  int           m_k    [2];
  int           m_p    [2];
  int           m_duty [2][CH];
  int           m_pend [2][CH];
  bit           m_pf   [2];
  bit [CH-1:0]  m_pwm  [2];
  bit           m_ps   [2];

  function automatic int mlen(input int d, input int p);
    if (p == 0) return 1;
    return (d == 0) ? p + 1 : 2 * p;
  endfunction

  function automatic int mcount(input int d, input int k, input int p);
    if (d == 0 || k <= p) return k;
    return 2 * p - k;
  endfunction

  task automatic model_step(input int d, input int per);
    int  cnt;
    bit  tick, acc, pol;
    pol = (d == 0);
    if (rst) begin
      m_k[d] = 0; m_p[d] = 0; m_pf[d] = 0; m_ps[d] = 0;
      m_pwm[d] = pol ? '0 : '1;
      for (int i = 0; i < CH; i++) begin m_duty[d][i] = 0; m_pend[d][i] = 0; end
      return;
    end
    cnt  = mcount(d, m_k[d], m_p[d]);
    tick = !en || (m_k[d] == mlen(d, m_p[d]) - 1);
    for (int i = 0; i < CH; i++)
      m_pwm[d][i] = en ? ((m_duty[d][i] > cnt) ? pol : !pol) : !pol;
    m_ps[d] = tick && en;
    acc = duty_valid && !m_pf[d];
    if (tick) begin
      m_k[d] = 0;
      m_p[d] = per;
      if (m_pf[d]) begin
        for (int i = 0; i < CH; i++) m_duty[d][i] = m_pend[d][i];
        m_pf[d] = 0;
      end
    end else begin
      m_k[d] = m_k[d] + 1;
    end
    if (acc) begin
      for (int i = 0; i < CH; i++) m_pend[d][i] = int'(duty_in[i*W +: W]);
      m_pf[d] = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0, int'(period_e));
    model_step(1, int'(period_c));
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("e_count", int'(cnt_e), mcount(0, m_k[0], m_p[0]));
      chk("e_ready", int'(ready_e), int'(!m_pf[0]));
      chk("e_pwm",   int'(pwm_e), int'(m_pwm[0]));
      chk("e_ps",    int'(ps_e), int'(m_ps[0]));
      chk("c_count", int'(cnt_c), mcount(1, m_k[1], m_p[1]));
      chk("c_ready", int'(ready_c), int'(!m_pf[1]));
      chk("c_pwm",   int'(pwm_c), int'(m_pwm[1]));
      chk("c_ps",    int'(ps_c), int'(m_ps[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until the next edge-instance period_start (bounded)
  task automatic wait_ps_e(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!ps_e && gap < 40);
  endtask

  int e_hi [CH];
  int c_act [CH];
  int e_ps_n, c_ps_n, g, g2;

  initial begin
    cyc(3);
    checking = 1'b1;
    chk("rst_count", int'(cnt_e), 0);
    chk("rst_ready", int'(ready_e), 1);
    chk("rst_pwm_e", int'(pwm_e), 0);
    chk("rst_pwm_c", int'(pwm_c), 15);
    chk("rst_ps", int'(ps_e), 0);

    // ch0=3 ch1=0 ch2=15 ch3=4; edge P=9, centre P=8
    rst = 1'b0;
    duty_in = {4'd4, 4'd15, 4'd0, 4'd3};
    duty_valid = 1'b1;
    period_e = 4'd9;
    period_c = 4'd8;
    en = 1'b1;
    cyc(1);
    duty_valid = 1'b0;
    cyc(50);

    for (int i = 0; i < CH; i++) begin e_hi[i] = 0; c_act[i] = 0; end
    e_ps_n = 0; c_ps_n = 0;
    for (int t = 0; t < 32; t++) begin
      cyc(1);
      for (int i = 0; i < CH; i++) begin
        if (t < 20 && pwm_e[i]) e_hi[i]++;
        if (!pwm_c[i]) c_act[i]++;
      end
      if (t < 20 && ps_e) e_ps_n++;
      if (ps_c) c_ps_n++;
    end
    chk("edge_d3_hi20", e_hi[0], 6);
    chk("edge_d0_hi20", e_hi[1], 0);
    chk("edge_d15_hi20", e_hi[2], 20);
    chk("edge_d4_hi20", e_hi[3], 8);
    chk("edge_ps20", e_ps_n, 2);
    chk("ctr_d3_act32", c_act[0], 10);
    chk("ctr_d0_act32", c_act[1], 0);
    chk("ctr_d15_act32", c_act[2], 32);
    chk("ctr_d4_act32", c_act[3], 14);
    chk("ctr_ps32", c_ps_n, 2);

    // Double-buffer stall: d=2 then d=7 while pending is full
    duty_in = {4'd4, 4'd15, 4'd0, 4'd2};
    duty_valid = 1'b1;
    cyc(1);
    chk("stall_ready", int'(ready_e), 0);
    duty_in = {4'd4, 4'd15, 4'd0, 4'd7};
    g = 0;
    while (!ready_e && g < 30) begin cyc(1); g++; end
    chk("stall_released", int'(ready_e), 1);
    cyc(1);
    duty_valid = 1'b0;
    cyc(30);
    e_hi[0] = 0;
    for (int t = 0; t < 20; t++) begin cyc(1); if (pwm_e[0]) e_hi[0]++; end
    chk("edge_d7_hi20", e_hi[0], 14);

    // Period change 9 -> 4 mid-period
    wait_ps_e(g);
    cyc(3);
    period_e = 4'd4;
    wait_ps_e(g);
    chk("pchg_cur_len", g + 3, 10);
    wait_ps_e(g2);
    chk("pchg_next_len", g2, 5);

    // P=0 holds the counter at 0, every cycle is a boundary
    period_e = 4'd0;
    cyc(20);
    chk("p0_count", int'(cnt_e), 0);
    chk("p0_ps", int'(ps_e), 1);
    period_e = 4'd9;
    cyc(15);

    // Reset with a word pending
    duty_in = {4'd1, 4'd2, 4'd3, 4'd4};
    duty_valid = 1'b1;
    cyc(1);
    duty_valid = 1'b0;
    chk("pend_ready", int'(ready_e), 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mrst_count", int'(cnt_e), 0);
    chk("mrst_ready", int'(ready_e), 1);
    chk("mrst_pwm_e", int'(pwm_e), 0);
    chk("mrst_pwm_c", int'(pwm_c), 15);

    // Disable
    duty_in = {4'd9, 4'd9, 4'd9, 4'd9};
    duty_valid = 1'b1;
    cyc(1);
    duty_valid = 1'b0;
    cyc(25);
    en = 1'b0;
    cyc(2);
    chk("dis_count", int'(cnt_e), 0);
    chk("dis_pwm_e", int'(pwm_e), 0);
    chk("dis_pwm_c", int'(pwm_c), 15);
    chk("dis_count_c", int'(cnt_c), 0);
    en = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      rst        = ($urandom % 250) == 0;
      en         = ($urandom % 16) != 0;
      duty_valid = ($urandom % 4) == 0;
      duty_in    = CH*W'($urandom);
      if (($urandom % 20) == 0) period_e = ($urandom % 4 == 0) ? 4'd15 : W'($urandom % 16);
      if (($urandom % 20) == 0) period_c = ($urandom % 4 == 0) ? 4'd15 : W'($urandom % 16);
      cyc(1);
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
